// File: rtl/tdc_meas_ctrl.sv
// TDC measurement controller: bubble-corrects and encodes start/stop thermometer
// snapshots, extends range with a coarse cycle counter, and reports via valid/ready.
module tdc_meas_ctrl #(
  parameter int TAPS       = 8,
  parameter int COARSE_W   = 8,
  parameter int CNT_W      = 16,
  parameter int AUTO_REARM = 0,
  parameter int RES_W      = COARSE_W + $clog2(TAPS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             start_hit,
  input  logic [TAPS-1:0]  start_code,
  input  logic             stop_hit,
  input  logic [TAPS-1:0]  stop_code,
  input  logic             result_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [RES_W-1:0] result,
  output logic             overflow,
  output logic             bubble_err,
  output logic             order_err,
  output logic [CNT_W-1:0] meas_count
);

  localparam int FW = $clog2(TAPS + 1);
  localparam int EW = RES_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Majority-of-three across neighbours, with implied 1 below tap 0 and 0 above the top tap.
  function automatic logic [TAPS-1:0] bubble_fix(input logic [TAPS-1:0] c);
    logic [TAPS+1:0] e;
    logic [TAPS-1:0] corr;
    e = {1'b0, c, 1'b1};
    for (int i = 0; i < TAPS; i++) begin
      corr[i] = (e[i] & e[i+1]) | (e[i] & e[i+2]) | (e[i+1] & e[i+2]);
    end
    return corr;
  endfunction

  function automatic logic [FW-1:0] popcount(input logic [TAPS-1:0] c);
    logic [FW-1:0] n;
    n = '0;
    for (int i = 0; i < TAPS; i++) begin
      n = n + FW'(c[i]);
    end
    return n;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [COARSE_W-1:0] elapsed_q, elapsed_d;
  logic [FW-1:0]       fs_q, fs_d;
  logic                sbub_q, sbub_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                bub_q, bub_d;
  logic                ord_q, ord_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, valid_q;

  logic [TAPS-1:0]     start_corr_s, stop_corr_s;
  logic                start_bub_s, stop_bub_s;
  logic [FW-1:0]       fstart_s, fstop_s;
  logic [COARSE_W-1:0] coarse_s;
  logic [EW-1:0]       pos_s, neg_s;
  logic                neg_res_s;
  logic [RES_W-1:0]    calc_s;

  // Encode snapshots and form the interval; ARMED covers the same-cycle start/stop case.
  always_comb begin
    start_corr_s = bubble_fix(start_code);
    stop_corr_s  = bubble_fix(stop_code);
    start_bub_s  = (start_corr_s != start_code);
    stop_bub_s   = (stop_corr_s != stop_code);
    fstop_s      = popcount(stop_corr_s);
    if (state_q == S_RUN) begin
      fstart_s = fs_q;
      coarse_s = elapsed_q;
    end else begin
      fstart_s = popcount(start_corr_s);
      coarse_s = '0;
    end
    pos_s     = EW'(coarse_s) * EW'(TAPS) + EW'(fstart_s);
    neg_s     = EW'(fstop_s);
    neg_res_s = (pos_s < neg_s);
    if (neg_res_s) begin
      calc_s = '0;
    end else begin
      calc_s = RES_W'(pos_s - neg_s);
    end
  end

  // Measurement sequencing: arm, capture start, count, report, wait for accept.
  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    fs_d      = fs_q;
    sbub_d    = sbub_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    bub_d     = bub_q;
    ord_d     = ord_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_ARMED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED: begin
        if (start_hit) begin
          fs_d      = fstart_s;
          sbub_d    = start_bub_s;
          elapsed_d = COARSE_W'(1);
          ovf_d     = 1'b0;
          bub_d     = 1'b0;
          ord_d     = 1'b0;
          if (stop_hit) begin
            state_d  = S_DONE;
            result_d = calc_s;
            ord_d    = neg_res_s;
            bub_d    = start_bub_s | stop_bub_s;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_ARMED;
        end
      end
      S_RUN: begin
        if (stop_hit) begin
          state_d  = S_DONE;
          result_d = calc_s;
          ord_d    = neg_res_s;
          bub_d    = sbub_q | stop_bub_s;
        end else if (elapsed_q == {COARSE_W{1'b1}}) begin
          state_d  = S_DONE;
          ovf_d    = 1'b1;
          result_d = {RES_W{1'b1}};
          bub_d    = sbub_q;
        end else begin
          elapsed_d = elapsed_q + COARSE_W'(1);
        end
      end
      S_DONE: begin
        if (result_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (AUTO_REARM != 0) ? S_ARMED : S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      elapsed_q <= '0;
      fs_q      <= '0;
      sbub_q    <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      bub_q     <= 1'b0;
      ord_q     <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      fs_q      <= fs_d;
      sbub_q    <= sbub_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      bub_q     <= bub_d;
      ord_q     <= ord_d;
      cnt_q     <= cnt_d;
      busy_q    <= (state_d == S_ARMED) || (state_d == S_RUN);
      valid_q   <= (state_d == S_DONE);
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result       = result_q;
  assign overflow     = ovf_q;
  assign bubble_err   = bub_q;
  assign order_err    = ord_q;
  assign meas_count   = cnt_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl: one task per scenario with hand-computed expectations.
module tb_tdc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, arm, start_hit, stop_hit, result_ready;
  logic [7:0]  start_code, stop_code;
  logic        busy, result_valid, overflow, bubble_err, order_err;
  logic [11:0] result;
  logic [15:0] meas_count;
  logic        busy2, result_valid2, overflow2, bubble_err2, order_err2;
  logic [11:0] result2;
  logic [15:0] meas_count2;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  tdc_meas_ctrl #(.TAPS(8), .COARSE_W(8), .CNT_W(16), .AUTO_REARM(0)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .start_hit(start_hit), .start_code(start_code),
    .stop_hit(stop_hit), .stop_code(stop_code), .result_ready(result_ready), .busy(busy),
    .result_valid(result_valid), .result(result), .overflow(overflow), .bubble_err(bubble_err),
    .order_err(order_err), .meas_count(meas_count));

  tdc_meas_ctrl #(.TAPS(8), .COARSE_W(8), .CNT_W(16), .AUTO_REARM(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .start_hit(start_hit), .start_code(start_code),
    .stop_hit(stop_hit), .stop_code(stop_code), .result_ready(result_ready), .busy(busy2),
    .result_valid(result_valid2), .result(result2), .overflow(overflow2), .bubble_err(bubble_err2),
    .order_err(order_err2), .meas_count(meas_count2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic do_accept();
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", result_valid); end
    checks++; if (result !== 12'd0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
    checks++; if ({overflow, bubble_err, order_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {overflow, bubble_err, order_err}); end
    checks++; if (meas_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", meas_count); end
    rst_n = 1'b1; tick();
    exp_cnt = 0;
  endtask

  task automatic test_basic();
    do_arm();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_armed_busy got %b want 1", busy); end
    start_hit = 1'b1; start_code = 8'h1F; tick(); start_hit = 1'b0;
    tick(); tick();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", result_valid); end
    stop_hit = 1'b1; stop_code = 8'h07; tick(); stop_hit = 1'b0;
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", result_valid); end
    checks++; if (result !== 12'd26) begin errors++; $display("FAIL basic_result got %0d want 26", result); end
    checks++; if ({overflow, bubble_err, order_err} !== 3'b000) begin errors++; $display("FAIL basic_flags got %b want 000", {overflow, bubble_err, order_err}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_done_busy got %b want 0", busy); end
    do_accept();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", result_valid); end
    checks++; if (meas_count !== 16'(exp_cnt)) begin errors++; $display("FAIL basic_count got %0d want %0d", meas_count, exp_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_same_cycle();
    do_arm();
    start_hit = 1'b1; start_code = 8'h7F; stop_hit = 1'b1; stop_code = 8'h03; tick();
    start_hit = 1'b0; stop_hit = 1'b0;
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL same_valid got %b want 1", result_valid); end
    checks++; if (result !== 12'd5) begin errors++; $display("FAIL same_result got %0d want 5", result); end
    checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL same_order got %b want 0", order_err); end
    do_accept();
    do_arm();
    start_hit = 1'b1; start_code = 8'h03; stop_hit = 1'b1; stop_code = 8'h3F; tick();
    start_hit = 1'b0; stop_hit = 1'b0;
    checks++; if (result !== 12'd0) begin errors++; $display("FAIL order_result got %0d want 0", result); end
    checks++; if (order_err !== 1'b1) begin errors++; $display("FAIL order_flag got %b want 1", order_err); end
    do_accept();
    checks++; if (meas_count !== 16'(exp_cnt)) begin errors++; $display("FAIL same_count got %0d want %0d", meas_count, exp_cnt); end
  endtask

  task automatic test_bubble();
    do_arm();
    start_hit = 1'b1; start_code = 8'h17; tick(); start_hit = 1'b0;
    checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL bubble_order_clear got %b want 0", order_err); end
    tick();
    stop_hit = 1'b1; stop_code = 8'h01; tick(); stop_hit = 1'b0;
    checks++; if (result !== 12'd19) begin errors++; $display("FAIL bubble_result got %0d want 19", result); end
    checks++; if (bubble_err !== 1'b1) begin errors++; $display("FAIL bubble_flag got %b want 1", bubble_err); end
    do_accept();
  endtask

  task automatic test_overflow();
    do_arm();
    start_hit = 1'b1; start_code = 8'h0F; tick(); start_hit = 1'b0;
    checks++; if (bubble_err !== 1'b0) begin errors++; $display("FAIL ovf_bubble_clear got %b want 0", bubble_err); end
    repeat (254) tick();
    checks++; if ({busy, result_valid} !== 2'b10) begin errors++; $display("FAIL ovf_early got %b want 10", {busy, result_valid}); end
    tick();
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", result_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (result !== 12'hFFF) begin errors++; $display("FAIL ovf_result got %h want fff", result); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if ({result_valid, overflow, result} !== {2'b11, 12'hFFF}) begin errors++; $display("FAIL ovf_hold cycle %0d got %b/%h want 11/fff", i, {result_valid, overflow}, result); end
    end
    do_accept();
    checks++; if ({busy, result_valid} !== 2'b00) begin errors++; $display("FAIL ovf_accept got %b want 00", {busy, result_valid}); end
    checks++; if (meas_count !== 16'(exp_cnt)) begin errors++; $display("FAIL ovf_count got %0d want %0d", meas_count, exp_cnt); end
  endtask

  task automatic test_ignored();
    do_arm();
    stop_hit = 1'b1; stop_code = 8'hFF; tick(); stop_hit = 1'b0;
    checks++; if ({busy, result_valid} !== 2'b10) begin errors++; $display("FAIL ign_stop_armed got %b want 10", {busy, result_valid}); end
    start_hit = 1'b1; start_code = 8'hFF; tick(); start_hit = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    start_hit = 1'b1; start_code = 8'h01; tick(); start_hit = 1'b0;
    stop_hit = 1'b1; stop_code = 8'hFF; tick(); stop_hit = 1'b0;
    checks++; if (result !== 12'd24) begin errors++; $display("FAIL ign_run_result got %0d want 24", result); end
    start_hit = 1'b1; stop_hit = 1'b1; start_code = 8'h01; stop_code = 8'h01; arm = 1'b1; tick();
    start_hit = 1'b0; stop_hit = 1'b0; arm = 1'b0;
    checks++; if ({result_valid, result} !== {1'b1, 12'd24}) begin errors++; $display("FAIL ign_done_hits got %b/%0d want 1/24", result_valid, result); end
    do_accept();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle got %b want 0", busy); end
  endtask

  task automatic test_auto_rearm();
    rst_n = 1'b0; tick(); rst_n = 1'b1; exp_cnt = 0;
    do_arm();
    start_hit = 1'b1; start_code = 8'h0F; stop_hit = 1'b1; stop_code = 8'h01; tick();
    start_hit = 1'b0; stop_hit = 1'b0;
    checks++; if ({result_valid2, result2} !== {1'b1, 12'd3}) begin errors++; $display("FAIL rearm_result got %b/%0d want 1/3", result_valid2, result2); end
    do_accept();
    checks++; if ({busy2, result_valid2} !== 2'b10) begin errors++; $display("FAIL rearm_armed got %b want 10", {busy2, result_valid2}); end
    checks++; if (meas_count2 !== 16'd1) begin errors++; $display("FAIL rearm_count got %0d want 1", meas_count2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL norearm_idle got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    do_arm();
    start_hit = 1'b1; start_code = 8'h0F; tick(); start_hit = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_run got %b want 1", busy); end
    rst_n = 1'b0; tick();
    checks++; if ({busy, result_valid, overflow, bubble_err, order_err} !== 5'b00000) begin errors++; $display("FAIL rstmid_flags got %b want 00000", {busy, result_valid, overflow, bubble_err, order_err}); end
    checks++; if ({result, meas_count} !== 28'd0) begin errors++; $display("FAIL rstmid_data got %0d/%0d want 0/0", result, meas_count); end
    rst_n = 1'b1; exp_cnt = 0; tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b want 0", busy); end
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; start_hit = 1'b0; stop_hit = 1'b0; result_ready = 1'b0;
    start_code = 8'h00; stop_code = 8'h00;
    test_reset();
    test_basic();
    test_same_cycle();
    test_bubble();
    test_overflow();
    test_ignored();
    test_auto_rearm();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
Parametrised successor to the 8-tap thermometer TDC front end. It takes synchronised start/stop hit strobes plus their captured delay-line thermometer snapshots, bubble-corrects and encodes them to fine values, and extends range with a coarse cycle counter. Measurements are sequenced by an arm/measure/report FSM with a valid/ready result handshake. It sits between the delay-line capture flops and the readout logic.

Parameters:
TAPS, 8, thermometer width per snapshot (>=4)
COARSE_W, 8, coarse cycle counter width
CNT_W, 16, completed-measurement counter width
AUTO_REARM, 0, 1 = return to ARMED instead of IDLE after result accepted
RES_W, COARSE_W+$clog2(TAPS)+1, result width (derived, do not override)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
arm  input  1  request a measurement; honoured only in IDLE
start_hit  input  1  one-cycle strobe: start edge captured this cycle
start_code  input  TAPS  start thermometer snapshot, valid with start_hit
stop_hit  input  1  one-cycle strobe: stop edge captured this cycle
stop_code  input  TAPS  stop thermometer snapshot, valid with stop_hit
result_ready  input  1  consumer accepts result
busy  output  1  high in ARMED or RUN
result_valid  output  1  result/flags valid
result  output  RES_W  interval in tap units
overflow  output  1  no stop within coarse range
bubble_err  output  1  bubble corrected in either snapshot
order_err  output  1  same-cycle stop earlier than start, result clamped
meas_count  output  CNT_W  completed measurements, wraps

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; all outputs 0, counters 0. Takes effect mid-operation; any measurement in progress is discarded.
- Fine encode: c[-1]=1, c[TAPS]=0; corr[i]=majority(c[i-1],c[i],c[i+1]); fine = popcount(corr), range 0..TAPS. bubble flag if corr != raw code.
- Fine convention: larger fine = earlier edge within its cycle.
- Coarse = stop_hit cycle index minus start_hit cycle index (0 if same cycle).
- result = coarse*TAPS + fine_start - fine_stop. If negative (only possible when coarse=0): result=0, order_err=1.
- FSM:
  - IDLE: arm -> ARMED. Hits ignored.
  - ARMED: start_hit -> RUN, latch fine_start and its bubble flag. start_hit and stop_hit in the same cycle -> DONE with coarse=0. stop_hit alone is ignored.
  - RUN: elapsed counts cycles since start. stop_hit -> DONE. Further start_hit and arm are ignored. If elapsed = 2^COARSE_W-1 and no stop_hit that cycle -> DONE with overflow=1 and result = all ones.
  - DONE: result_valid=1; result and flags held stable until result_ready. On result_valid & result_ready: meas_count+1 (wraps at 2^CNT_W), result_valid drops next cycle, state -> IDLE (AUTO_REARM=0) or ARMED (AUTO_REARM=1).
- Latency: result_valid rises on the clk edge after the cycle in which stop_hit is sampled.
- Hits arriving in DONE are dropped.
- bubble_err = OR of start and stop flags. Flags clear when a new measurement starts (ARMED -> RUN).
- busy=1 exactly in ARMED and RUN.

Test Plan:
- Defaults; arm; start_hit with 0x1F (fine 5); stop_hit 3 cycles later with 0x07 (fine 3) -> result=26, result_valid the next cycle, flags 0, meas_count=1 after ready.
- Same-cycle start 0x7F and stop 0x03 -> result=5. Same-cycle start 0x03 and stop 0x3F -> result=0, order_err=1.
- Start code 0x17 (bubble) corrects to 0x0F (fine 4); stop 0x01 two cycles later -> result=19, bubble_err=1.
- Armed, start, no stop for 255 cycles -> overflow=1, result=0xFFF. Hold result_ready low 10 cycles -> outputs stable; assert ready -> IDLE, busy=0.
- stop_hit while ARMED, and arm while RUN -> both ignored; AUTO_REARM=1 -> ARMED after accept. rst_n low during RUN -> IDLE, all outputs 0 next edge.
